fetch_unit: RTL

Parametrised, decoupled instruction fetch unit. It owns the PC register and issues requests to a synchronous instruction memory. Returned instructions are buffered with their PCs in a DEPTH-entry prefetch FIFO. The FIFO head is decoded into RV32 fields behind a valid/ready handshake. Sits between the instruction memory and the decode/execute stage, replacing the single-instruction, externally-PC-driven fetch stage.

---
 rtl/fetch_pkg.sv | 49 ++++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : RV32 opcode constants, fetch entry type and immediate generator
// Revision    : 1.0
// ============================================================================
package fetch_pkg;

    localparam int FETCH_ILEN = 32;
    localparam int FETCH_XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [FETCH_ILEN-1:0] pc;
        logic [FETCH_ILEN-1:0] inst;
    } fetch_entry_t;

    // Returns the 32-bit sign-extended immediate; unknown opcodes give 0.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst);
        logic [31:0] imm;
        imm = '0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'b0};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Generic DEPTH-entry synchronous FIFO with flush and occupancy
// Revision    : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !flush_i && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Decoupled fetch unit: PC, credit-based imem requests, prefetch
//               FIFO and RV32 field decode. FETCH_STATS_EN adds counters.
// Revision    : 1.0
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ILEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [ILEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [ILEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [9:0]      func,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] valC
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    import fetch_pkg::*;

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     c_DEPTH    = (CW+1)'(DEPTH);
    localparam logic [ILEN-1:0] c_PC_STEP  = ILEN'(4);
    localparam logic [ILEN-1:0] c_ALIGN_MK = ~ILEN'(3);

    logic [ILEN-1:0]   pc_q;
    logic [ILEN-1:0]   pc_d;
    logic [ILEN-1:0]   inflight_pc_q;
    logic              inflight_q;
    logic              kill_q;

    logic [CW-1:0]     w_count;
    logic [CW:0]       w_used;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [2*ILEN-1:0] w_head;
    logic [ILEN-1:0]   w_inst;
    logic [31:0]       w_imm;
    logic [ILEN-1:0]   w_redirect_pc;

    // A request is only issued when a FIFO slot is guaranteed for its response.
    assign w_used        = {1'b0, w_count} + {{CW{1'b0}}, inflight_q};
    assign imem_req      = !reset && !redirect && (w_used < c_DEPTH);
    assign imem_addr     = pc_q;
    assign w_redirect_pc = redirect_pc & c_ALIGN_MK;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = w_redirect_pc;
        end else if (imem_req) begin
            pc_d = pc_q + c_PC_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            kill_q     <= redirect;
            if (imem_req) inflight_pc_q <= pc_q;
        end
    end

    // Responses belonging to a flushed stream never reach the FIFO.
    assign w_push    = inflight_q && !kill_q && !redirect && (!w_full || w_pop);
    assign out_valid = !w_empty && !redirect && !reset;
    assign w_pop     = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*ILEN)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (w_push),
        .wdata_i ({inflight_pc_q, imem_rdata}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign out_pc = w_head[2*ILEN-1:ILEN];
    assign w_inst = w_head[ILEN-1:0];
    assign opcode = w_inst[6:0];
    assign func   = {w_inst[31:25], w_inst[14:12]};
    assign rs1    = w_inst[19:15];
    assign rs2    = w_inst[24:20];
    assign rd     = w_inst[11:7];
    assign w_imm  = imm_gen(w_inst[31:0]);
    assign valC   = XLEN'($signed(w_imm));

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (w_pop)                   fetch_count_q <= fetch_count_q + 32'd1;
            if (out_valid && !out_ready) stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire
